// File: rtl/mem_responder_if.sv
// CPU-side bus and RAM preload handshake of mem_responder, grouped for port use.
// The shared data bus stays a separate inout port on the responder itself.
interface mem_responder_if #(
    parameter int RAM_AW = 10
) ();
    logic [7:0]        abh;
    logic [7:0]        abl;
    logic              rw;
    logic              sync;
    logic              irq;
    logic              nmi;
    logic              ld_valid;
    logic              ld_ready;
    logic [RAM_AW-1:0] ld_addr;
    logic [7:0]        ld_data;

    modport master (
        output abh, abl, rw, sync, ld_valid, ld_addr, ld_data,
        input  irq, nmi, ld_ready
    );

    modport slave (
        input  abh, abl, rw, sync, ld_valid, ld_addr, ld_data,
        output irq, nmi, ld_ready
    );
endinterface

// File: rtl/mem_responder.sv
// 6502 bus responder: RAM window, vector page, I/O page (timer, NMI trigger, fetch counter).
// Define MEM_RESPONDER_TIMER_EN to build the interval timer and irq; otherwise they are absent.
module mem_responder #(
    parameter int          RAM_AW    = 10,
    parameter logic [7:0]  IO_PAGE   = 8'hD0,
    parameter logic [15:0] RESET_VEC = 16'h0200,
    parameter logic [15:0] IRQ_VEC   = 16'h0300,
    parameter logic [15:0] NMI_VEC   = 16'h0380,
    parameter int          NMI_LEN   = 4
) (
    input  logic            clk,
    input  logic            clr,
    mem_responder_if.slave  bus,
    inout  wire  [7:0]      dataio
);
    localparam int RAM_DEPTH = 1 << RAM_AW;

    logic [15:0] addr;
    logic        ram_sel, io_sel, vec_sel, io_wr;
    logic [2:0]  io_idx;
    logic [7:0]  wdata, vec_rdata, io_rdata, tmr_rdata, rd_next, rd_out;

    assign addr    = {bus.abh, bus.abl};
    assign ram_sel = (addr >> RAM_AW) == 16'd0;
    assign io_sel  = !ram_sel && (bus.abh == IO_PAGE);
    assign vec_sel = (bus.abh == 8'hFF) && (bus.abl >= 8'hFA);
    assign io_idx  = bus.abl[2:0];
    assign io_wr   = !bus.rw && io_sel;
    assign wdata   = dataio;

    logic [7:0] fcnt_reg, rdata_reg;
    logic [3:0] nmi_cnt_reg;
    logic       nmi_reg, oe_reg, ram_rd_reg;

    // RAM: one write port shared by CPU and preload, registered read port.
    logic [7:0]        ram [RAM_DEPTH];
    logic [7:0]        ram_q_reg;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_waddr;
    logic [7:0]        ram_wdata;

    assign bus.ld_ready = bus.ld_valid && bus.rw && clr;

    always_comb begin
        ram_we    = clr && ((!bus.rw && ram_sel) || bus.ld_ready);
        ram_waddr = bus.rw ? bus.ld_addr : addr[RAM_AW-1:0];
        ram_wdata = bus.rw ? bus.ld_data : wdata;
    end

    always_ff @(posedge clk) begin
        if (ram_we)
            ram[ram_waddr] <= ram_wdata;
        ram_q_reg <= ram[addr[RAM_AW-1:0]];
    end

    always_comb begin
        case (bus.abl[2:0])
            3'd2:    vec_rdata = NMI_VEC[7:0];
            3'd3:    vec_rdata = NMI_VEC[15:8];
            3'd4:    vec_rdata = RESET_VEC[7:0];
            3'd5:    vec_rdata = RESET_VEC[15:8];
            3'd6:    vec_rdata = IRQ_VEC[7:0];
            3'd7:    vec_rdata = IRQ_VEC[15:8];
            default: vec_rdata = 8'hFF;
        endcase
        case (io_idx)
            3'd0, 3'd1, 3'd2, 3'd3: io_rdata = tmr_rdata;
            3'd5:                   io_rdata = fcnt_reg;
            default:                io_rdata = 8'h00;
        endcase
        if (io_sel)
            rd_next = io_rdata;
        else if (vec_sel)
            rd_next = vec_rdata;
        else
            rd_next = 8'hFF;
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            oe_reg      <= 1'b0;
            ram_rd_reg  <= 1'b0;
            rdata_reg   <= 8'h00;
            fcnt_reg    <= 8'h00;
            nmi_cnt_reg <= 4'd0;
            nmi_reg     <= 1'b0;
        end else begin
            oe_reg     <= bus.rw;
            ram_rd_reg <= ram_sel;
            rdata_reg  <= rd_next;
            fcnt_reg   <= fcnt_reg + {7'd0, bus.sync};
            if (io_wr && io_idx == 3'd4) begin
                nmi_reg     <= 1'b1;
                nmi_cnt_reg <= 4'(NMI_LEN - 1);
            end else if (nmi_cnt_reg != 4'd0) begin
                nmi_cnt_reg <= nmi_cnt_reg - 4'd1;
            end else begin
                nmi_reg <= 1'b0;
            end
        end
    end

    assign bus.nmi = nmi_reg;
    assign rd_out  = ram_rd_reg ? ram_q_reg : rdata_reg;
    // Read data is released while the CPU drives a write, so the two never fight.
    assign dataio  = (oe_reg && bus.rw) ? rd_out : 8'hzz;

`ifdef MEM_RESPONDER_TIMER_EN
    logic [7:0]  tlo_reg, thi_reg;
    logic        en_reg, irqen_reg, oneshot_reg, exp_reg, irq_reg;
    logic [15:0] cnt_reg, cnt_next, reload;
    logic        en_next, hit, ctrl_wr;

    always_comb begin
        reload   = {thi_reg, tlo_reg};
        ctrl_wr  = io_wr && io_idx == 3'd2;
        cnt_next = cnt_reg;
        en_next  = en_reg;
        hit      = 1'b0;
        // A CTRL write overrides whatever the running count would do this cycle.
        if (ctrl_wr) begin
            en_next  = wdata[0];
            cnt_next = reload;
            hit      = wdata[0] && reload == 16'd0;
            if (hit && wdata[2])
                en_next = 1'b0;
        end else if (en_reg) begin
            cnt_next = (cnt_reg == 16'd0) ? reload : cnt_reg - 16'd1;
            hit      = cnt_next == 16'd0;
            if (hit && oneshot_reg)
                en_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            tlo_reg     <= 8'h00;
            thi_reg     <= 8'h00;
            en_reg      <= 1'b0;
            irqen_reg   <= 1'b0;
            oneshot_reg <= 1'b0;
            exp_reg     <= 1'b0;
            irq_reg     <= 1'b0;
            cnt_reg     <= 16'd0;
        end else begin
            if (io_wr && io_idx == 3'd0) tlo_reg <= wdata;
            if (io_wr && io_idx == 3'd1) thi_reg <= wdata;
            if (ctrl_wr) begin
                irqen_reg   <= wdata[1];
                oneshot_reg <= wdata[2];
            end
            en_reg  <= en_next;
            cnt_reg <= cnt_next;
            if (hit)
                exp_reg <= 1'b1;
            else if (io_wr && io_idx == 3'd3 && wdata[0])
                exp_reg <= 1'b0;
            irq_reg <= exp_reg && irqen_reg;
        end
    end

    always_comb begin
        case (io_idx)
            3'd0:    tmr_rdata = tlo_reg;
            3'd1:    tmr_rdata = thi_reg;
            3'd2:    tmr_rdata = {5'd0, oneshot_reg, irqen_reg, en_reg};
            3'd3:    tmr_rdata = {7'd0, exp_reg};
            default: tmr_rdata = 8'h00;
        endcase
    end

    assign bus.irq = irq_reg;
`else
    assign tmr_rdata = 8'h00;
    assign bus.irq   = 1'b0;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// Directed, table-driven bench for mem_responder; the data bus has pull-ups so Hi-Z reads as 8'hFF.
`timescale 1ns/1ps
module tb_mem_responder;
    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if #(.RAM_AW(10)) bus ();
    wire  [7:0] dataio;
    logic       tb_drive = 1'b0;
    logic [7:0] tb_data  = 8'h00;
    assign dataio = tb_drive ? tb_data : 8'hzz;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pu
            pullup (dataio[gi]);
        end
    endgenerate

    mem_responder #(
        .RAM_AW(10), .IO_PAGE(8'hD0), .RESET_VEC(16'h0200),
        .IRQ_VEC(16'h0300), .NMI_VEC(16'h0380), .NMI_LEN(4)
    ) dut (
        .clk(clk), .clr(clr), .bus(bus), .dataio(dataio)
    );

    localparam logic [7:0] HIZ = 8'hFF;

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_data;
        logic        exp_irq;
        logic        exp_nmi;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    logic ldr_pre;
    vec_t tbl[$];

    function automatic vec_t mk(logic rw, logic [15:0] a, logic [7:0] w,
                                logic [7:0] d, logic i, logic n);
        vec_t v;
        v.rw = rw; v.addr = a; v.wdata = w; v.exp_data = d; v.exp_irq = i; v.exp_nmi = n;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%02h required=%02h", name, act, req);
        end
    endtask

    // One bus cycle; afterwards rw is parked high so dataio shows only the responder's drive.
    task automatic step(input logic rw, input logic [15:0] a, input logic [7:0] w, input logic sy);
        bus.abh  = a[15:8];
        bus.abl  = a[7:0];
        bus.rw   = rw;
        bus.sync = sy;
        tb_data  = w;
        tb_drive = !rw;
        #1;
        ldr_pre = bus.ld_ready;
        @(posedge clk);
        #1;
        tb_drive = 1'b0;
        bus.rw   = 1'b1;
        #1;
        $display("t=%0t %s addr=%04h wdata=%02h dataio=%02h irq=%0b nmi=%0b",
                 $time, rw ? "RD" : "WR", a, w, dataio, bus.irq, bus.nmi);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rw, tbl[i].addr, tbl[i].wdata, 1'b0);
            check($sformatf("%s[%0d].data", tag, i), dataio, tbl[i].exp_data);
            check($sformatf("%s[%0d].irq", tag, i), {7'd0, bus.irq}, {7'd0, tbl[i].exp_irq});
            check($sformatf("%s[%0d].nmi", tag, i), {7'd0, bus.nmi}, {7'd0, tbl[i].exp_nmi});
        end
        tbl.delete();
    endtask

    initial begin
        bus.abh = 8'h00; bus.abl = 8'h00; bus.rw = 1'b1; bus.sync = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_addr = 10'h000; bus.ld_data = 8'h00;

        // Reset state, with a preload request pending that must not be accepted
        repeat (2) @(posedge clk);
        #2;
        check("rst.dataio", dataio, HIZ);
        check("rst.irq", {7'd0, bus.irq}, 8'h00);
        check("rst.nmi", {7'd0, bus.nmi}, 8'h00);
        check("rst.ld_ready", {7'd0, bus.ld_ready}, 8'h00);
        bus.ld_valid = 1'b0;
        clr = 1'b1;

        // Vectors, RAM, unmapped, I/O holes, then NMI pulse shapes
        tbl.push_back(mk(1, 16'hFFFC, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(1, 16'hFFFD, 8'h00, 8'h02, 0, 0));
        tbl.push_back(mk(0, 16'hFFFC, 8'hAB, HIZ,   0, 0));
        tbl.push_back(mk(1, 16'hFFFC, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(1, 16'hFFFE, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(1, 16'hFFFF, 8'h00, 8'h03, 0, 0));
        tbl.push_back(mk(1, 16'hFFFA, 8'h00, 8'h80, 0, 0));
        tbl.push_back(mk(1, 16'hFFFB, 8'h00, 8'h03, 0, 0));
        tbl.push_back(mk(1, 16'hFFF9, 8'h00, 8'hFF, 0, 0));
        tbl.push_back(mk(0, 16'h0123, 8'h5A, HIZ,   0, 0));
        tbl.push_back(mk(1, 16'h0123, 8'h00, 8'h5A, 0, 0));
        tbl.push_back(mk(1, 16'h8000, 8'h00, 8'hFF, 0, 0));
        tbl.push_back(mk(0, 16'h03FF, 8'h00, HIZ,   0, 0));
        tbl.push_back(mk(1, 16'h03FF, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(1, 16'h0400, 8'h00, 8'hFF, 0, 0));
        tbl.push_back(mk(0, 16'h0000, 8'hC3, HIZ,   0, 0));
        tbl.push_back(mk(1, 16'h0000, 8'h00, 8'hC3, 0, 0));
        tbl.push_back(mk(1, 16'hD005, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(1, 16'hD006, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(1, 16'hD007, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 16'hD004, 8'h00, HIZ,   0, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 16'hD004, 8'h00, 8'h00, 0, 1));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 16'hD006, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 16'hD004, 8'h00, HIZ,   0, 1));
        tbl.push_back(mk(1, 16'hD006, 8'h00, 8'h00, 0, 1));
        tbl.push_back(mk(0, 16'hD004, 8'h00, HIZ,   0, 1));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 16'hD006, 8'h00, 8'h00, 0, 1));
        tbl.push_back(mk(1, 16'hD006, 8'h00, 8'h00, 0, 0));
        run_table("main");

        // Preload arbitration: CPU write wins, next read cycle accepts the preload
        bus.ld_valid = 1'b1; bus.ld_addr = 10'h010; bus.ld_data = 8'h77;
        step(0, 16'h0010, 8'h11, 1'b0);
        check("pl.ready_on_write", {7'd0, ldr_pre}, 8'h00);
        step(1, 16'h0040, 8'h00, 1'b0);
        check("pl.ready_on_read", {7'd0, ldr_pre}, 8'h01);
        bus.ld_valid = 1'b0;
        step(1, 16'h0010, 8'h00, 1'b0);
        check("pl.readback", dataio, 8'h77);

        // Fetch counter through its wrap
        for (int i = 0; i < 255; i++) step(1, 16'h0000, 8'h00, 1'b1);
        step(1, 16'hD005, 8'h00, 1'b0);
        check("fcnt.255", dataio, 8'hFF);
        for (int i = 0; i < 2; i++) step(1, 16'h0000, 8'h00, 1'b1);
        step(1, 16'hD005, 8'h00, 1'b0);
        check("fcnt.257", dataio, 8'h01);

`ifdef MEM_RESPONDER_TIMER_EN
        // Periodic R=5: CTRL write at k=0, EXP at k=5/11/17, irq one cycle later
        tbl.push_back(mk(0, 16'hD000, 8'h05, HIZ, 0, 0));
        tbl.push_back(mk(0, 16'hD001, 8'h00, HIZ, 0, 0));
        tbl.push_back(mk(0, 16'hD002, 8'h03, HIZ, 0, 0));
        for (int k = 1; k <= 6; k++) tbl.push_back(mk(1, 16'hD003, 8'h00, (k >= 6) ? 8'h01 : 8'h00, k >= 6, 0));
        tbl.push_back(mk(0, 16'hD003, 8'h01, HIZ, 1, 0));
        for (int k = 8; k <= 13; k++) tbl.push_back(mk(1, 16'hD003, 8'h00, (k >= 12) ? 8'h01 : 8'h00, k >= 12, 0));
        tbl.push_back(mk(0, 16'hD003, 8'h01, HIZ, 1, 0));
        tbl.push_back(mk(1, 16'hD003, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(1, 16'hD003, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 16'hD003, 8'h01, HIZ, 0, 0));
        tbl.push_back(mk(1, 16'hD003, 8'h00, 8'h01, 1, 0));
        tbl.push_back(mk(1, 16'hD002, 8'h00, 8'h03, 1, 0));
        tbl.push_back(mk(1, 16'hD000, 8'h00, 8'h05, 1, 0));
        tbl.push_back(mk(0, 16'hD003, 8'h01, HIZ, 1, 0));
        // One-shot: exactly one expiry, EN self-clears
        tbl.push_back(mk(0, 16'hD002, 8'h07, HIZ, 0, 0));
        for (int j = 1; j <= 6; j++) tbl.push_back(mk(1, 16'hD003, 8'h00, (j >= 6) ? 8'h01 : 8'h00, j >= 6, 0));
        tbl.push_back(mk(0, 16'hD003, 8'h01, HIZ, 1, 0));
        for (int j = 8; j <= 14; j++) tbl.push_back(mk(1, 16'hD003, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(1, 16'hD002, 8'h00, 8'h06, 0, 0));
        // Restart periodic so reset lands on a running count with irq high
        tbl.push_back(mk(0, 16'hD002, 8'h03, HIZ, 0, 0));
        for (int j = 1; j <= 6; j++) tbl.push_back(mk(1, 16'hD003, 8'h00, (j >= 6) ? 8'h01 : 8'h00, j >= 6, 0));
        run_table("timer");
`else
        tbl.push_back(mk(0, 16'hD000, 8'h05, HIZ, 0, 0));
        tbl.push_back(mk(0, 16'hD001, 8'h00, HIZ, 0, 0));
        tbl.push_back(mk(0, 16'hD002, 8'h03, HIZ, 0, 0));
        tbl.push_back(mk(1, 16'hD000, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(1, 16'hD001, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(1, 16'hD002, 8'h00, 8'h00, 0, 0));
        for (int j = 0; j < 8; j++) tbl.push_back(mk(1, 16'hD003, 8'h00, 8'h00, 0, 0));
        run_table("notimer");
`endif

        // Reset mid-operation: NMI pulse and timer count both abort
        step(0, 16'hD004, 8'h00, 1'b0);
        check("mid.nmi_started", {7'd0, bus.nmi}, 8'h01);
        clr = 1'b0;
        @(posedge clk);
        #2;
        check("mid.irq", {7'd0, bus.irq}, 8'h00);
        check("mid.nmi", {7'd0, bus.nmi}, 8'h00);
        check("mid.dataio", dataio, HIZ);
        clr = 1'b1;
        step(1, 16'hD005, 8'h00, 1'b0);
        check("mid.fcnt", dataio, 8'h00);
        step(1, 16'hD002, 8'h00, 1'b0);
        check("mid.ctrl", dataio, 8'h00);
        for (int j = 0; j < 8; j++) begin
            step(1, 16'hD003, 8'h00, 1'b0);
            check($sformatf("mid.stat%0d", j), dataio, 8'h00);
            check($sformatf("mid.irq%0d", j), {7'd0, bus.irq}, 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
